// File: rtl/fir_stream_ctrl_if.sv
// Avalon-ST link between the stream controller and the FIR core:
// the sample sink path and the result source path.
interface fir_stream_ctrl_if;
  logic [11:0] sink_data;
  logic        sink_valid;
  logic        sink_ready;
  logic [1:0]  sink_error;
  logic [24:0] source_data;
  logic        source_valid;
  logic [1:0]  source_error;
  logic        source_ready;

  modport master (
    output sink_data, sink_valid, sink_error, source_ready,
    input  sink_ready, source_data, source_valid, source_error
  );

  modport slave (
    input  sink_data, sink_valid, sink_error, source_ready,
    output sink_ready, source_data, source_valid, source_error
  );
endinterface

// File: rtl/fir_stream_ctrl.sv
// ADC-to-FIR stream sequencer: paced capture, offset-binary conversion, sample FIFO,
// drain plus zero flush on stop, and registered FIR result capture with error reporting.
module fir_stream_ctrl #(
  parameter int DIV_W      = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int FLUSH_LEN  = 64
) (
  input  logic             sys_clk,
  input  logic             sys_rst_n,
  input  logic             start,
  input  logic             stop,
  input  logic [DIV_W-1:0] div,
  input  logic [9:0]       data_in,
  fir_stream_ctrl_if.master ast,
  output logic [24:0]      dout,
  output logic             dout_valid,
  output logic             busy,
  output logic             err,
  output logic [7:0]       ovf_cnt
);

  localparam int AW  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW  = AW + 1;
  localparam int FCW = $clog2(FLUSH_LEN + 1);
  localparam logic [CW-1:0]  FULL_C      = CW'(FIFO_DEPTH);
  localparam logic [FCW-1:0] FLUSH_LAST_C = FCW'(FLUSH_LEN - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2
  } state_t;

  function automatic logic [11:0] offset_to_signed(input logic [9:0] raw);
    return {{3{~raw[9]}}, raw[8:0]};
  endfunction

  state_t           state_r;
  state_t           state_s;
  logic [DIV_W-1:0] div_l_r;
  logic [DIV_W-1:0] div_cnt_r;
  logic [11:0]      mem_r [FIFO_DEPTH];
  logic [AW-1:0]    rd_ptr_r;
  logic [AW-1:0]    wr_ptr_r;
  logic [CW-1:0]    count_r;
  logic [FCW-1:0]   flush_cnt_r;
  logic             busy_r;
  logic             err_r;
  logic [7:0]       ovf_cnt_r;
  logic [24:0]      dout_r;
  logic             dout_valid_r;

  logic empty_s, full_s, run_s, start_s, tick_s;
  logic pop_s, push_s, drop_s, zero_phase_s, zero_acc_s, src_err_s;

  assign empty_s      = (count_r == CW'(0));
  assign full_s       = (count_r == FULL_C);
  assign run_s        = (state_r == ST_RUN);
  assign start_s      = (state_r == ST_IDLE) && start && !stop;
  assign tick_s       = run_s && (div_cnt_r == div_l_r);
  assign pop_s        = !empty_s && ast.sink_ready;
  assign push_s       = tick_s && (!full_s || pop_s);
  assign drop_s       = tick_s && full_s && !pop_s;
  assign zero_phase_s = (state_r == ST_FLUSH) && empty_s;
  assign zero_acc_s   = zero_phase_s && ast.sink_ready;
  assign src_err_s    = ast.source_valid && (ast.source_error != 2'b00);

  // Sink side is a pure decode of FIFO registers; the flush phase presents literal zeros.
  assign ast.sink_data    = empty_s ? 12'h000 : mem_r[rd_ptr_r];
  assign ast.sink_valid   = !empty_s || zero_phase_s;
  assign ast.sink_error   = 2'b00;
  assign ast.source_ready = 1'b1;

  assign dout       = dout_r;
  assign dout_valid = dout_valid_r;
  assign busy       = busy_r;
  assign err        = err_r;
  assign ovf_cnt    = ovf_cnt_r;

  // FSM state register
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // FSM next-state logic
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (start && !stop) state_s = ST_RUN;
        else                state_s = ST_IDLE;
      end
      ST_RUN: begin
        if (stop) state_s = ST_FLUSH;
        else      state_s = ST_RUN;
      end
      ST_FLUSH: begin
        if (zero_acc_s && (flush_cnt_r == FLUSH_LAST_C)) state_s = ST_IDLE;
        else                                             state_s = ST_FLUSH;
      end
      default: state_s = ST_IDLE;
    endcase
  end

  // Sample-rate divider: counts 0..div_l and ticks on the terminal value
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      div_l_r   <= '0;
      div_cnt_r <= '0;
    end else if (start_s) begin
      div_l_r   <= div;
      div_cnt_r <= '0;
    end else if (run_s) begin
      div_cnt_r <= tick_s ? DIV_W'(0) : div_cnt_r + DIV_W'(1);
    end else begin
      div_cnt_r <= div_cnt_r;
    end
  end

  // Sample FIFO storage and pointers; a pop in the same cycle frees room for a push when full
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem_r[i] <= 12'h000;
      rd_ptr_r <= '0;
      wr_ptr_r <= '0;
      count_r  <= '0;
    end else begin
      if (push_s) begin
        mem_r[wr_ptr_r] <= offset_to_signed(data_in);
        wr_ptr_r        <= wr_ptr_r + AW'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1);
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CW'(1);
        2'b01:   count_r <= count_r - CW'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Zero-flush handshake counter
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      flush_cnt_r <= '0;
    end else if (zero_acc_s) begin
      flush_cnt_r <= (flush_cnt_r == FLUSH_LAST_C) ? FCW'(0) : flush_cnt_r + FCW'(1);
    end else begin
      flush_cnt_r <= flush_cnt_r;
    end
  end

  // Status: busy tracks the next state so it falls right after the last flush accept
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      busy_r    <= 1'b0;
      err_r     <= 1'b0;
      ovf_cnt_r <= 8'd0;
    end else begin
      busy_r <= (state_s != ST_IDLE);
      err_r  <= (err_r && !start_s) || drop_s || src_err_s;
      if (start_s) begin
        ovf_cnt_r <= 8'd0;
      end else if (drop_s && (ovf_cnt_r != 8'hFF)) begin
        ovf_cnt_r <= ovf_cnt_r + 8'd1;
      end else begin
        ovf_cnt_r <= ovf_cnt_r;
      end
    end
  end

  // FIR result capture, active in every state
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      dout_r       <= 25'd0;
      dout_valid_r <= 1'b0;
    end else begin
      dout_valid_r <= ast.source_valid;
      if (ast.source_valid) begin
        dout_r <= ast.source_data;
      end else begin
        dout_r <= dout_r;
      end
    end
  end

endmodule

// File: tb/tb_fir_stream_ctrl.sv
// Directed self-checking bench for fir_stream_ctrl with hand-computed expectations.
module tb_fir_stream_ctrl;
  logic       sys_clk;
  logic       sys_rst_n;
  logic       start;
  logic       stop;
  logic [7:0] div;
  logic [9:0] data_in;
  logic [24:0] dout;
  logic       dout_valid;
  logic       busy;
  logic       err;
  logic [7:0] ovf_cnt;

  int chk_cnt = 0;
  int err_cnt = 0;

  fir_stream_ctrl_if ast ();

  fir_stream_ctrl #(.DIV_W(8), .FIFO_DEPTH(4), .FLUSH_LEN(64)) dut (
    .sys_clk    (sys_clk),
    .sys_rst_n  (sys_rst_n),
    .start      (start),
    .stop       (stop),
    .div        (div),
    .data_in    (data_in),
    .ast        (ast),
    .dout       (dout),
    .dout_valid (dout_valid),
    .busy       (busy),
    .err        (err),
    .ovf_cnt    (ovf_cnt)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    chk_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick_clk();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic wait_idle(input string tag);
    for (int i = 0; i < 300 && busy; i++) tick_clk();
    check_val(tag, 32'(busy), 32'd0);
  endtask

  // Counts zero-sample handshakes until busy drops; expects exactly 64, the last one right before
  task automatic flush_count(input string tag);
    int   n;
    logic last_acc;
    n = 0;
    last_acc = 1'b0;
    for (int i = 0; i < 300 && busy; i++) begin
      if (ast.sink_valid && ast.sink_ready && (ast.sink_data == 12'h000)) begin
        n++;
        last_acc = 1'b1;
      end else begin
        last_acc = 1'b0;
      end
      tick_clk();
    end
    check_val({tag, "_zero_cnt"}, 32'(n), 32'd64);
    check_val({tag, "_last_acc"}, 32'(last_acc), 32'd1);
    check_val({tag, "_busy_low"}, 32'(busy), 32'd0);
    check_val({tag, "_valid_low"}, 32'(ast.sink_valid), 32'd0);
  endtask

  initial begin
    int bad;
    sys_rst_n = 1'b0;
    start = 1'b0;
    stop = 1'b0;
    div = 8'd0;
    data_in = 10'd0;
    ast.sink_ready = 1'b0;
    ast.source_data = 25'd0;
    ast.source_valid = 1'b0;
    ast.source_error = 2'b00;

    // reset state
    repeat (3) @(posedge sys_clk);
    #1;
    check_val("rst_sink_valid", 32'(ast.sink_valid), 32'd0);
    check_val("rst_sink_data", 32'(ast.sink_data), 32'd0);
    check_val("rst_sink_error", 32'(ast.sink_error), 32'd0);
    check_val("rst_source_ready", 32'(ast.source_ready), 32'd1);
    check_val("rst_busy", 32'(busy), 32'd0);
    check_val("rst_err", 32'(err), 32'd0);
    check_val("rst_ovf", 32'(ovf_cnt), 32'd0);
    check_val("rst_dout", 32'(dout), 32'd0);
    check_val("rst_dout_valid", 32'(dout_valid), 32'd0);
    sys_rst_n = 1'b1;
    tick_clk();

    // 1: conversion ramp at full rate
    div = 8'd0;
    ast.sink_ready = 1'b1;
    data_in = 10'd0;
    start = 1'b1;
    tick_clk();
    start = 1'b0;
    check_val("t1_valid_e0", 32'(ast.sink_valid), 32'd0);
    tick_clk();
    check_val("t1_s0", 32'(ast.sink_data), 32'h0000_0E00);
    check_val("t1_v0", 32'(ast.sink_valid), 32'd1);
    data_in = 10'd512;
    tick_clk();
    check_val("t1_s512", 32'(ast.sink_data), 32'h0000_0000);
    data_in = 10'd1023;
    tick_clk();
    check_val("t1_s1023", 32'(ast.sink_data), 32'h0000_01FF);
    check_val("t1_ovf", 32'(ovf_cnt), 32'd0);
    check_val("t1_err", 32'(err), 32'd0);
    check_val("t1_busy", 32'(busy), 32'd1);
    stop = 1'b1;
    tick_clk();
    stop = 1'b0;
    wait_idle("t1_idle");

    // 2: div=3 pacing
    div = 8'd3;
    data_in = 10'd700;
    start = 1'b1;
    tick_clk();
    start = 1'b0;
    bad = 0;
    for (int k = 1; k <= 12; k++) begin
      tick_clk();
      if (ast.sink_valid !== ((k % 4) == 0)) bad++;
      if (k == 4) check_val("t2_data", 32'(ast.sink_data), 32'h0000_00BC);
    end
    check_val("t2_pace_errors", 32'(bad), 32'd0);
    check_val("t2_busy", 32'(busy), 32'd1);
    stop = 1'b1;
    tick_clk();
    stop = 1'b0;
    wait_idle("t2_idle");

    // 3: back-pressure, overflow, then ordered drain and flush
    div = 8'd0;
    ast.sink_ready = 1'b0;
    data_in = 10'd16;
    start = 1'b1;
    tick_clk();
    start = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      data_in = 10'(16 * k);
      if (k == 10) stop = 1'b1;
      tick_clk();
      stop = 1'b0;
      if (k == 5) check_val("t3_hold_e5", 32'(ast.sink_data), 32'h0000_0E10);
    end
    check_val("t3_hold_e10", 32'(ast.sink_data), 32'h0000_0E10);
    check_val("t3_valid", 32'(ast.sink_valid), 32'd1);
    check_val("t3_ovf", 32'(ovf_cnt), 32'd6);
    check_val("t3_err", 32'(err), 32'd1);
    ast.sink_ready = 1'b1;
    tick_clk();
    check_val("t3_s2", 32'(ast.sink_data), 32'h0000_0E20);
    tick_clk();
    check_val("t3_s3", 32'(ast.sink_data), 32'h0000_0E30);
    tick_clk();
    check_val("t3_s4", 32'(ast.sink_data), 32'h0000_0E40);
    tick_clk();
    check_val("t3_zero_valid", 32'(ast.sink_valid), 32'd1);
    flush_count("t3_flush");

    // 4: stop with two queued samples, start ignored in FLUSH
    ast.sink_ready = 1'b0;
    data_in = 10'd600;
    start = 1'b1;
    tick_clk();
    start = 1'b0;
    check_val("t4_ovf_clr", 32'(ovf_cnt), 32'd0);
    check_val("t4_err_clr", 32'(err), 32'd0);
    tick_clk();
    data_in = 10'd400;
    stop = 1'b1;
    tick_clk();
    stop = 1'b0;
    check_val("t4_head1", 32'(ast.sink_data), 32'h0000_0058);
    start = 1'b1;
    ast.sink_ready = 1'b1;
    tick_clk();
    start = 1'b0;
    check_val("t4_head2", 32'(ast.sink_data), 32'h0000_0F90);
    check_val("t4_busy", 32'(busy), 32'd1);
    tick_clk();
    check_val("t4_zero_data", 32'(ast.sink_data), 32'd0);
    check_val("t4_zero_valid", 32'(ast.sink_valid), 32'd1);
    flush_count("t4_flush");

    // 5: FIR result capture with source error
    ast.sink_ready = 1'b0;
    ast.source_data = 25'h1FF_FFFB;
    ast.source_valid = 1'b1;
    ast.source_error = 2'b01;
    tick_clk();
    ast.source_valid = 1'b0;
    ast.source_error = 2'b00;
    check_val("t5_dout", 32'(dout), 32'h01FF_FFFB);
    check_val("t5_dout_valid", 32'(dout_valid), 32'd1);
    check_val("t5_err", 32'(err), 32'd1);
    tick_clk();
    check_val("t5_dout_valid_low", 32'(dout_valid), 32'd0);
    check_val("t5_dout_hold", 32'(dout), 32'h01FF_FFFB);
    div = 8'd0;
    data_in = 10'd900;
    start = 1'b1;
    tick_clk();
    start = 1'b0;
    check_val("t5_err_clr", 32'(err), 32'd0);
    check_val("t5_ovf_clr", 32'(ovf_cnt), 32'd0);
    tick_clk();
    tick_clk();
    check_val("t5_queued", 32'(ast.sink_data), 32'h0000_0184);

    // 6: asynchronous reset mid-RUN
    #3;
    sys_rst_n = 1'b0;
    #1;
    check_val("t6_valid", 32'(ast.sink_valid), 32'd0);
    check_val("t6_data", 32'(ast.sink_data), 32'd0);
    check_val("t6_busy", 32'(busy), 32'd0);
    check_val("t6_dout", 32'(dout), 32'd0);
    check_val("t6_source_ready", 32'(ast.source_ready), 32'd1);
    tick_clk();
    sys_rst_n = 1'b1;
    ast.sink_ready = 1'b1;
    bad = 0;
    for (int k = 0; k < 10; k++) begin
      tick_clk();
      if (ast.sink_valid !== 1'b0 || busy !== 1'b0) bad++;
    end
    check_val("t6_no_flush", 32'(bad), 32'd0);

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end
endmodule
